fetch_stage: RTL and testbench

//  IF stage of the pipelined CPU: owns the PC, drives the instruction memory address and loads the IF/ID register.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/pc_next_sel.sv | 29 ++
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: next-PC select, NOP word, branch controller commands.
// Used by fetch_stage (optional counter enabled by FETCH_FLUSH_CNT_EN).
package fetch_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2,
    PC_RET = 2'd3
  } pcsel_t;

  localparam int FETCH_IW = 19;
  localparam logic [FETCH_IW-1:0] NOP_INSTR = '0;

  localparam logic [1:0] BC_CMD_SEQ = 2'd0;
  localparam logic [1:0] BC_CMD_BR  = 2'd1;
  localparam logic [1:0] BC_CMD_JMP = 2'd2;
  localparam logic [1:0] BC_CMD_RET = 2'd3;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC select: sequential, branch, jump or return.
// All arithmetic wraps modulo 2^AW.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] ifid_pc1,
  input  logic [AW-1:0] br_offset,
  input  logic [AW-1:0] jmp_target,
  input  logic [AW-1:0] ret_addr,
  input  pcsel_t        sel,
  output logic [AW-1:0] pc_next
);

  // Branches are relative to the PC+1 held in IF/ID
  always_comb begin
    pc_next = pc + AW'(1);
    unique case (sel)
      PC_SEQ: pc_next = pc + AW'(1);
      PC_BR:  pc_next = ifid_pc1 + br_offset;
      PC_JMP: pc_next = jmp_target;
      PC_RET: pc_next = ret_addr;
      default: pc_next = pc + AW'(1);
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, imem address, IF/ID register, optional redirect counter.
// Define FETCH_FLUSH_CNT_EN to build the saturating flush_count counter.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int AW = 12,
  parameter int IW = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          flush,
  input  logic [1:0]    PCmux,
  input  logic [AW-1:0] br_offset,
  input  logic [AW-1:0] jmp_target,
  input  logic [AW-1:0] ret_addr,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] ifid_instr,
  output logic [AW-1:0] ifid_pc1,
  output logic          ifid_valid,
  output logic [15:0]   flush_count
);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc1_q;
  logic [IW-1:0] instr_q;
  logic          valid_q;
  pcsel_t        sel;
  logic          squash;

  assign sel       = pcsel_t'(PCmux);
  assign squash    = flush | (sel != PC_SEQ);
  assign imem_addr = pc_q;

  pc_next_sel #(.AW(AW)) u_sel (
    .pc         (pc_q),
    .ifid_pc1   (pc1_q),
    .br_offset  (br_offset),
    .jmp_target (jmp_target),
    .ret_addr   (ret_addr),
    .sel        (sel),
    .pc_next    (pc_d)
  );

  // PC and IF/ID: frozen on hold, bubble on any squash
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      pc1_q   <= '0;
      instr_q <= IW'(NOP_INSTR);
      valid_q <= 1'b0;
    end else if (!hold) begin
      pc_q  <= pc_d;
      pc1_q <= pc_q + AW'(1);
      if (squash) begin
        instr_q <= IW'(NOP_INSTR);
        valid_q <= 1'b0;
      end else begin
        instr_q <= imem_rdata;
        valid_q <= 1'b1;
      end
    end
  end

  assign ifid_instr = instr_q;
  assign ifid_pc1   = pc1_q;
  assign ifid_valid = valid_q;

`ifdef FETCH_FLUSH_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Count taken redirects/squashes, saturating
  always_comb begin
    cnt_d = cnt_q;
    if (!hold && squash && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign flush_count = cnt_q;
`else
  assign flush_count = '0;
`endif

  // The select must be known whenever it is acted on
  a_pcmux_known: assert property (
    @(posedge clk) disable iff (!rst_n)
    !hold |-> !$isunknown(PCmux)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with a behavioural fetch model.
// Counter expectations follow FETCH_FLUSH_CNT_EN.
module tb_fetch_stage;
  localparam int AW = 12;
  localparam int IW = 19;
  localparam int MSK = (1 << AW) - 1;
`ifdef FETCH_FLUSH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic [1:0]    PCmux = 2'd0;
  logic [AW-1:0] br_offset = '0;
  logic [AW-1:0] jmp_target = '0;
  logic [AW-1:0] ret_addr = '0;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata;
  logic [IW-1:0] ifid_instr;
  logic [AW-1:0] ifid_pc1;
  logic          ifid_valid;
  logic [15:0]   flush_count;

  int n_chk = 0;
  int n_err = 0;

  int m_pc, m_pc1, m_cnt;
  logic [IW-1:0] m_instr;
  bit m_valid;

  fetch_stage #(.AW(AW), .IW(IW)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .PCmux(PCmux), .br_offset(br_offset),
    .jmp_target(jmp_target), .ret_addr(ret_addr),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_instr(ifid_instr), .ifid_pc1(ifid_pc1),
    .ifid_valid(ifid_valid), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
    return {a[6:0] ^ 7'h2A, a};
  endfunction

  assign imem_rdata = mem(imem_addr);

  task automatic model_reset();
    m_pc = 0; m_pc1 = 0; m_cnt = 0;
    m_instr = '0; m_valid = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model, sample after the edge
  task automatic cyc(input bit h, input bit f, input int s,
                     input int off, input int jt, input int ra);
    int npc;
    bit sq;
    hold = h; flush = f; PCmux = 2'(s);
    br_offset = AW'(off); jmp_target = AW'(jt); ret_addr = AW'(ra);
    if (!h) begin
      case (s)
        0: npc = m_pc + 1;
        1: npc = m_pc1 + off;
        2: npc = jt;
        default: npc = ra;
      endcase
      sq = f || (s != 0);
      m_instr = sq ? '0 : mem(AW'(m_pc));
      m_valid = !sq;
      m_pc1 = (m_pc + 1) & MSK;
      m_pc = npc & MSK;
      if (CNT_EN && sq && m_cnt < 65535) m_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if (imem_addr !== '0 || ifid_valid !== 1'b0 || ifid_pc1 !== '0
        || ifid_instr !== '0 || flush_count !== 16'd0) begin
      n_err++;
      $display("FAIL reset got addr=%h v=%b pc1=%h ins=%h cnt=%0d req all 0",
               imem_addr, ifid_valid, ifid_pc1, ifid_instr, flush_count);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_seq();
    n_chk++;
    if (imem_addr !== 12'h000 || ifid_valid !== 1'b0) begin
      n_err++;
      $display("FAIL seq_first got addr=%h v=%b req 000 0", imem_addr, ifid_valid);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      n_chk++;
      if (imem_addr !== AW'(i + 1) || ifid_pc1 !== AW'(i + 1)
          || ifid_valid !== 1'b1 || ifid_instr !== mem(AW'(i))) begin
        n_err++;
        $display("FAIL seq_%0d got addr=%h pc1=%h v=%b ins=%h req %h %h 1 %h",
                 i, imem_addr, ifid_pc1, ifid_valid, ifid_instr,
                 AW'(i + 1), AW'(i + 1), mem(AW'(i)));
      end
    end
  endtask

  task automatic test_branch();
    cyc(0, 0, 2, 0, 'h009, 0);
    cyc(0, 0, 2, 0, 'h010, 0);
    n_chk++;
    if (imem_addr !== 12'h010 || ifid_pc1 !== 12'h00A) begin
      n_err++;
      $display("FAIL br_setup got addr=%h pc1=%h req 010 00a", imem_addr, ifid_pc1);
    end
    cyc(0, 1, 1, -3, 0, 0);
    n_chk++;
    if (imem_addr !== 12'h007 || ifid_valid !== 1'b0) begin
      n_err++;
      $display("FAIL br_target got addr=%h v=%b req 007 0", imem_addr, ifid_valid);
    end
    cyc(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (ifid_valid !== 1'b1 || ifid_instr !== mem(12'h007) || ifid_pc1 !== 12'h008) begin
      n_err++;
      $display("FAIL br_land got v=%b ins=%h pc1=%h req 1 %h 008",
               ifid_valid, ifid_instr, ifid_pc1, mem(12'h007));
    end
  endtask

  task automatic test_hold();
    logic [AW-1:0] a0, p0;
    logic [IW-1:0] i0;
    logic v0;
    a0 = imem_addr; p0 = ifid_pc1; i0 = ifid_instr; v0 = ifid_valid;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 2, 0, 'h123, 0);
      n_chk++;
      if (imem_addr !== a0 || ifid_pc1 !== p0 || ifid_instr !== i0
          || ifid_valid !== v0 || imem_addr !== AW'(m_pc)) begin
        n_err++;
        $display("FAIL hold_%0d got addr=%h pc1=%h ins=%h v=%b req %h %h %h %b",
                 i, imem_addr, ifid_pc1, ifid_instr, ifid_valid, a0, p0, i0, v0);
      end
    end
    cyc(0, 0, 2, 0, 'h123, 0);
    n_chk++;
    if (imem_addr !== 12'h123 || ifid_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_jump got addr=%h v=%b req 123 0", imem_addr, ifid_valid);
    end
  endtask

  task automatic test_wrap();
    cyc(0, 0, 2, 0, 'hFFF, 0);
    cyc(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (imem_addr !== 12'h000 || ifid_pc1 !== 12'h000
        || ifid_instr !== mem(12'hFFF) || ifid_valid !== 1'b1) begin
      n_err++;
      $display("FAIL wrap got addr=%h pc1=%h ins=%h v=%b req 000 000 %h 1",
               imem_addr, ifid_pc1, ifid_instr, ifid_valid, mem(12'hFFF));
    end
  endtask

  task automatic test_async_reset();
    cyc(0, 0, 0, 0, 0, 0);
    hold = 0; flush = 1; PCmux = 2'd3; ret_addr = 12'h055;
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (imem_addr !== '0 || ifid_valid !== 1'b0 || ifid_pc1 !== '0
        || ifid_instr !== '0 || flush_count !== 16'd0) begin
      n_err++;
      $display("FAIL async_rst got addr=%h v=%b pc1=%h ins=%h cnt=%0d req all 0",
               imem_addr, ifid_valid, ifid_pc1, ifid_instr, flush_count);
    end
    flush = 0; PCmux = 2'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    cyc(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (imem_addr !== 12'h001 || ifid_instr !== mem(12'h000) || ifid_valid !== 1'b1) begin
      n_err++;
      $display("FAIL async_resume got addr=%h ins=%h v=%b req 001 %h 1",
               imem_addr, ifid_instr, ifid_valid, mem(12'h000));
    end
  endtask

  task automatic test_counter();
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_reset();
    cyc(0, 0, 2, 0, 'h020, 0);
    cyc(1, 0, 1, 4, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 3, 0, 0, 'h040);
    cyc(1, 1, 2, 0, 'h300, 0);
    cyc(0, 1, 1, 2, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    n_chk++;
    if (flush_count !== (CNT_EN ? 16'd3 : 16'd0)) begin
      n_err++;
      $display("FAIL counter got %0d req %0d", flush_count, CNT_EN ? 3 : 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      int s;
      s = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 3));
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, s,
          int'($urandom_range(0, MSK)), int'($urandom_range(0, MSK)),
          int'($urandom_range(0, MSK)));
      n_chk++;
      if (imem_addr !== AW'(m_pc) || ifid_pc1 !== AW'(m_pc1)
          || ifid_instr !== m_instr || ifid_valid !== m_valid
          || flush_count !== 16'(m_cnt)) begin
        n_err++;
        $display("FAIL rand_%0d got addr=%h pc1=%h ins=%h v=%b cnt=%0d req %h %h %h %b %0d",
                 i, imem_addr, ifid_pc1, ifid_instr, ifid_valid, flush_count,
                 AW'(m_pc), AW'(m_pc1), m_instr, m_valid, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_branch();
    test_hold();
    test_wrap();
    test_async_reset();
    test_counter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
